// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO stream reader.
//  occ_t       : occupancy state of the 2-entry output buffer
//  RD_LATENCY  : cycles from fifo_read to fifo_rdata being valid
package fifo_stream_reader_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    localparam int RD_LATENCY = 1;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Bus bundle between the FIFO, the stream reader and its downstream consumer.
//  fifo_empty  : FIFO empty flag (into reader)
//  fifo_read   : FIFO read strobe (from reader)
//  fifo_rdata  : FIFO read data, valid one cycle after fifo_read (into reader)
//  m_valid     : output word valid (from reader)
//  m_ready     : downstream accept (into reader)
//  m_data      : output word (from reader)
// The master modport is the reader's view; slave is the surrounding environment.
interface fifo_stream_reader_if #(
    parameter int width = 8
);
    logic             fifo_empty;
    logic             fifo_read;
    logic [width-1:0] fifo_rdata;
    logic             m_valid;
    logic             m_ready;
    logic [width-1:0] m_data;

    modport master (
        input  fifo_empty, fifo_rdata, m_ready,
        output fifo_read, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_rdata, m_ready,
        input  fifo_read, m_valid, m_data
    );
endinterface

// File: rtl/fifo_stream_reader_skid.sv
// Two-entry circular output buffer for the stream reader.
//  clk        : clock
//  clear      : synchronous clear (reset or flush), drops all contents
//  push       : write push_data at the tail this cycle
//  push_data  : word to write
//  pop        : retire the head word this cycle
//  head_data  : word at the head of the buffer
//  valid      : buffer holds at least one word
//  occupancy  : number of words held (0..2)
module fifo_skid_buffer
    import fifo_stream_reader_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] head_data,
    output logic             valid,
    output logic [1:0]       occupancy
);

    occ_t             state;
    occ_t             state_next;
    logic             head;
    logic             tail;
    logic [width-1:0] mem [2];

    // Occupancy state register; clear wins over any push/pop in the same cycle.
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= OCC_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Occupancy next state: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        state_next = state;
        case (state)
            OCC_EMPTY: if (push)         state_next = OCC_ONE;
            OCC_ONE:   if (push && !pop) state_next = OCC_TWO;
                       else if (pop && !push) state_next = OCC_EMPTY;
            OCC_TWO:   if (pop && !push) state_next = OCC_ONE;
            default:   state_next = OCC_EMPTY;
        endcase
    end

    // Storage and pointers. The words are zeroed on clear so the head reads 0 after reset.
    always_ff @(posedge clk) begin
        if (clear) begin
            head   <= 1'b0;
            tail   <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
        end
    end

    assign head_data = mem[head];
    assign valid     = (state != OCC_EMPTY);
    assign occupancy = state;

    // The read-issue logic must never let a word arrive into a full buffer unless the head leaves.
    assert property (@(posedge clk) disable iff (clear) !(push && !pop && state == OCC_TWO));

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side consumer of the FIFO: issues read strobes, captures the registered read data
// into a 2-entry buffer and presents it as a valid/ready stream.
//  clk        : clock
//  reset      : synchronous active-high reset
//  flush      : synchronous; drops buffered and in-flight words
//  bus        : FIFO read port and output stream (master modport)
//  occupancy  : words held in the output buffer (0..2)
//  drained    : FIFO empty, buffer empty and no read in flight
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int width = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    fifo_stream_reader_if.master  bus,
    output logic [1:0]            occupancy,
    output logic                  drained
);

    // One slot per cycle of read latency plus the word being presented keeps the stream gapless.
    localparam int DEPTH = RD_LATENCY + 1;

    logic       inflight;
    logic       pop;
    logic       clear;
    logic [2:0] outstanding;
    logic [2:0] demand;

    assign clear = reset | flush;
    assign pop   = bus.m_valid & bus.m_ready;

    // Words already claimed (buffered or returning), less the one leaving this cycle.
    assign outstanding   = {1'b0, occupancy} + {2'b00, inflight};
    assign demand        = outstanding - {2'b00, pop};
    assign bus.fifo_read = ~reset & ~flush & ~bus.fifo_empty & (demand < 3'(DEPTH));

    // Tracks the read issued last cycle; clearing it drops the word returning after a flush/reset.
    always_ff @(posedge clk) begin
        if (clear) begin
            inflight <= 1'b0;
        end else begin
            inflight <= bus.fifo_read;
        end
    end

    fifo_skid_buffer #(.width(width)) u_skid (
        .clk       (clk),
        .clear     (clear),
        .push      (inflight),
        .push_data (bus.fifo_rdata),
        .pop       (pop),
        .head_data (bus.m_data),
        .valid     (bus.m_valid),
        .occupancy (occupancy)
    );

    assign drained = bus.fifo_empty & (occupancy == 2'd0) & ~inflight;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a small behavioural FIFO (1-cycle read latency).
module tb_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [1:0] occupancy;
    logic       drained;

    always #5 clk = ~clk;

    fifo_stream_reader_if #(.width(8)) bus ();

    fifo_stream_reader #(.width(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy),
        .drained   (drained)
    );

    // Behavioural FIFO: contents written by the tasks, read pointer advanced by fifo_read.
    logic [7:0] fifo_mem [64];
    logic [5:0] rd_ptr = '0;
    logic [5:0] wr_ptr = '0;
    logic [7:0] rdata_q = '0;

    assign bus.fifo_empty = (rd_ptr == wr_ptr);
    assign bus.fifo_rdata = rdata_q;

    always @(posedge clk) begin
        if (bus.fifo_read) begin
            rdata_q <= fifo_mem[rd_ptr];
            rd_ptr  <= rd_ptr + 6'd1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic push_word(input logic [7:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; bus.m_ready = 1'b0;
        repeat (2) tick();
        #1;
        total++; if (bus.fifo_read !== 1'b0) begin bad++; $display("[TB] FAIL reset_read actual=%0b expected=0", bus.fifo_read); end
        reset = 1'b0;
        #1;
        total++; if (bus.m_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid actual=%0b expected=0", bus.m_valid); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("[TB] FAIL reset_occ actual=%0d expected=0", occupancy); end
        total++; if (bus.m_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data actual=%0h expected=0", bus.m_data); end
        total++; if (drained !== 1'b1) begin bad++; $display("[TB] FAIL reset_drained actual=%0b expected=1", drained); end
        total++; if (bus.fifo_read !== 1'b0) begin bad++; $display("[TB] FAIL idle_read actual=%0b expected=0", bus.fifo_read); end
    endtask

    task automatic test_stream();
        logic [7:0] exp_data;
        tick();
        bus.m_ready = 1'b1;
        push_word(8'h11); push_word(8'h22); push_word(8'h33);
        #1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin tick(); #1; end
            total++; if (bus.fifo_read !== (c < 3)) begin bad++; $display("[TB] FAIL stream_read c=%0d actual=%0b expected=%0b", c, bus.fifo_read, (c < 3)); end
            total++; if (bus.m_valid !== (c >= 2 && c <= 4)) begin bad++; $display("[TB] FAIL stream_valid c=%0d actual=%0b", c, bus.m_valid); end
            if (c >= 2 && c <= 4) begin
                exp_data = 8'(8'h11 * (c - 1));
                total++; if (bus.m_data !== exp_data) begin bad++; $display("[TB] FAIL stream_data c=%0d actual=%0h expected=%0h", c, bus.m_data, exp_data); end
            end
            total++; if (drained !== (c == 5)) begin bad++; $display("[TB] FAIL stream_drained c=%0d actual=%0b expected=%0b", c, drained, (c == 5)); end
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] start;
        logic [7:0] exp_data;
        tick();
        bus.m_ready = 1'b0;
        start = rd_ptr;
        push_word(8'hA0); push_word(8'hA1); push_word(8'hA2); push_word(8'hA3);
        #1;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) begin tick(); #1; end
            if (c >= 2) begin
                total++; if (bus.fifo_read !== 1'b0) begin bad++; $display("[TB] FAIL bp_read c=%0d actual=%0b expected=0", c, bus.fifo_read); end
            end
            if (c >= 3) begin
                total++; if (occupancy !== 2'd2) begin bad++; $display("[TB] FAIL bp_occ c=%0d actual=%0d expected=2", c, occupancy); end
                total++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'hA0) begin bad++; $display("[TB] FAIL bp_hold c=%0d valid=%0b data=%0h expected=A0", c, bus.m_valid, bus.m_data); end
            end
        end
        total++; if ((rd_ptr - start) !== 6'd2) begin bad++; $display("[TB] FAIL bp_reads actual=%0d expected=2", rd_ptr - start); end
        tick();
        bus.m_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin tick(); #1; end
            exp_data = 8'hA0 + 8'(k);
            total++; if (bus.m_valid !== 1'b1 || bus.m_data !== exp_data) begin bad++; $display("[TB] FAIL bp_stream k=%0d valid=%0b data=%0h expected=%0h", k, bus.m_valid, bus.m_data, exp_data); end
        end
        tick(); #1;
        total++; if (bus.m_valid !== 1'b0 || drained !== 1'b1) begin bad++; $display("[TB] FAIL bp_end valid=%0b drained=%0b expected 0/1", bus.m_valid, drained); end
    endtask

    task automatic test_toggle();
        int exp_idx;
        exp_idx = 0;
        tick();
        for (int w = 0; w < 16; w++) push_word(8'(w));
        for (int c = 0; c < 150 && exp_idx < 16; c++) begin
            if (c > 0) tick();
            bus.m_ready = (c % 2 == 0);
            #1;
            total++; if (occupancy > 2'd2) begin bad++; $display("[TB] FAIL toggle_occ c=%0d actual=%0d expected<=2", c, occupancy); end
            if (bus.m_valid && bus.m_ready) begin
                total++; if (bus.m_data !== 8'(exp_idx)) begin bad++; $display("[TB] FAIL toggle_data actual=%0h expected=%0h", bus.m_data, 8'(exp_idx)); end
                exp_idx++;
            end
        end
        total++; if (exp_idx !== 16) begin bad++; $display("[TB] FAIL toggle_count actual=%0d expected=16", exp_idx); end
        tick();
        bus.m_ready = 1'b1;
        repeat (3) tick();
        #1;
        total++; if (bus.m_valid !== 1'b0 || drained !== 1'b1) begin bad++; $display("[TB] FAIL toggle_extra valid=%0b drained=%0b expected 0/1", bus.m_valid, drained); end
    endtask

    task automatic test_flush();
        tick();
        bus.m_ready = 1'b0;
        push_word(8'h50); push_word(8'h51); push_word(8'h52); push_word(8'h53);
        #1;
        total++; if (bus.fifo_read !== 1'b1) begin bad++; $display("[TB] FAIL flush_pre_read0 actual=%0b expected=1", bus.fifo_read); end
        tick(); #1;
        total++; if (bus.fifo_read !== 1'b1) begin bad++; $display("[TB] FAIL flush_pre_read1 actual=%0b expected=1", bus.fifo_read); end
        tick();
        flush = 1'b1;
        #1;
        total++; if (occupancy !== 2'd1 || bus.m_data !== 8'h50) begin bad++; $display("[TB] FAIL flush_pre_state occ=%0d data=%0h expected 1/50", occupancy, bus.m_data); end
        total++; if (bus.fifo_read !== 1'b0) begin bad++; $display("[TB] FAIL flush_read actual=%0b expected=0", bus.fifo_read); end
        tick();
        flush = 1'b0;
        bus.m_ready = 1'b1;
        #1;
        total++; if (bus.m_valid !== 1'b0 || occupancy !== 2'd0) begin bad++; $display("[TB] FAIL flush_clear valid=%0b occ=%0d expected 0/0", bus.m_valid, occupancy); end
        for (int i = 0; i < 8 && !bus.m_valid; i++) begin tick(); #1; end
        total++;
        if (bus.m_valid !== 1'b1) begin bad++; $display("[TB] FAIL flush_timeout valid=%0b expected=1", bus.m_valid); end
        else if (bus.m_data !== 8'h52) begin bad++; $display("[TB] FAIL flush_next actual=%0h expected=52", bus.m_data); end
        tick(); #1;
        total++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h53) begin bad++; $display("[TB] FAIL flush_after valid=%0b data=%0h expected 1/53", bus.m_valid, bus.m_data); end
        repeat (2) tick();
        #1;
        total++; if (drained !== 1'b1) begin bad++; $display("[TB] FAIL flush_drained actual=%0b expected=1", drained); end
    endtask

    task automatic test_reset_midstream();
        tick();
        bus.m_ready = 1'b0;
        push_word(8'h60); push_word(8'h61); push_word(8'h62); push_word(8'h63);
        repeat (3) tick();
        #1;
        total++; if (occupancy !== 2'd2 || bus.m_data !== 8'h60) begin bad++; $display("[TB] FAIL rst_full occ=%0d data=%0h expected 2/60", occupancy, bus.m_data); end
        tick();
        bus.m_ready = 1'b1;
        #1;
        total++; if (bus.fifo_read !== 1'b1) begin bad++; $display("[TB] FAIL rst_refill_read actual=%0b expected=1", bus.fifo_read); end
        tick();
        bus.m_ready = 1'b0;
        reset = 1'b1;
        #1;
        total++; if (occupancy !== 2'd1 || bus.m_data !== 8'h61) begin bad++; $display("[TB] FAIL rst_pre occ=%0d data=%0h expected 1/61", occupancy, bus.m_data); end
        total++; if (bus.fifo_read !== 1'b0) begin bad++; $display("[TB] FAIL rst_read0 actual=%0b expected=0", bus.fifo_read); end
        tick(); #1;
        total++; if (bus.m_valid !== 1'b0 || occupancy !== 2'd0 || bus.m_data !== 8'h00) begin bad++; $display("[TB] FAIL rst_clear valid=%0b occ=%0d data=%0h expected 0/0/0", bus.m_valid, occupancy, bus.m_data); end
        total++; if (bus.fifo_read !== 1'b0) begin bad++; $display("[TB] FAIL rst_read1 actual=%0b expected=0", bus.fifo_read); end
        total++; if (drained !== 1'b0) begin bad++; $display("[TB] FAIL rst_drained actual=%0b expected=0", drained); end
        tick(); #1;
        total++; if (bus.fifo_read !== 1'b0) begin bad++; $display("[TB] FAIL rst_read2 actual=%0b expected=0", bus.fifo_read); end
        tick();
        reset = 1'b0;
        bus.m_ready = 1'b1;
        #1;
        for (int i = 0; i < 8 && !bus.m_valid; i++) begin tick(); #1; end
        total++;
        if (bus.m_valid !== 1'b1) begin bad++; $display("[TB] FAIL rst_timeout valid=%0b expected=1", bus.m_valid); end
        else if (bus.m_data !== 8'h63) begin bad++; $display("[TB] FAIL rst_next actual=%0h expected=63", bus.m_data); end
        repeat (2) tick();
        #1;
        total++; if (drained !== 1'b1) begin bad++; $display("[TB] FAIL rst_final_drained actual=%0b expected=1", drained); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle();
        test_flush();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the bench completed");
        $fatal(1, "[TB] watchdog");
    end

endmodule
